// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch port, the load/store port and the unified-memory port
// seen by mem_arbiter. The slave modport is the arbiter's view; the master
// modport is the view of the requesters and memory around it.
interface mem_arbiter_if;
    // fetch port
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_gnt;
    logic        i_rvalid;
    logic [31:0] i_rdata;
    // load/store port
    logic        d_req;
    logic        d_we;
    logic [2:0]  d_op;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        d_err;
    // memory port
    logic        mem_we;
    logic        mem_addrsrc;
    logic [2:0]  mem_memop;
    logic [31:0] mem_addr;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_op, d_addr, d_wdata, mem_rd,
        output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata, d_err,
               mem_we, mem_addrsrc, mem_memop, mem_addr, mem_wd
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_op, d_addr, d_wdata, mem_rd,
        input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata, d_err,
               mem_we, mem_addrsrc, mem_memop, mem_addr, mem_wd
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shares the unified instruction/data memory between fetch and load/store.
// One request is granted per arbitration (IDLE or RESP), the command drives
// the memory for exactly one ACCESS cycle, and the result is returned with a
// one-cycle rvalid in RESP. Data has priority; a saturating starvation count
// hands the next arbitration to fetch after STARVE_MAX consecutive losses.
module mem_arbiter #(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    mem_arbiter_if.slave  bus
);
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
    localparam logic [2:0] OP_W       = 3'b011;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    typedef struct packed {
        logic        fetch;
        logic        we;
        logic        err;
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] wd;
    } cmd_t;

    state_t      r_state, w_next;
    cmd_t        r_cmd, w_cmd;
    logic [3:0]  r_starve;
    logic [31:0] r_i_rdata, r_d_rdata;

    logic w_arb, w_below, w_i_win, w_d_win;

    // Illegal op for the direction, or misaligned halfword/word.
    function automatic logic f_illegal(input logic we, input logic [2:0] op,
                                       input logic [1:0] a);
        logic bad;
        if (we) bad = !(op inside {3'b001, 3'b010, 3'b011});
        else    bad = !(op inside {3'b001, 3'b010, 3'b011, 3'b100, 3'b101});
        if ((op == 3'b010 || op == 3'b101) && a[0]) bad = 1'b1;
        if (op == 3'b011 && a != 2'b00)             bad = 1'b1;
        return bad;
    endfunction

    // Arbitration: data first unless fetch has lost STARVE_MAX times in a row.
    always_comb begin
        w_arb   = (r_state != ACCESS);
        w_below = (r_starve < STARVE_LIM);
        w_d_win = w_arb && bus.d_req && (w_below || !bus.i_req);
        w_i_win = w_arb && bus.i_req && !(bus.d_req && w_below);
    end

    // Next state, command capture and grants.
    always_comb begin
        w_next    = r_state;
        w_cmd     = r_cmd;
        bus.i_gnt = 1'b0;
        bus.d_gnt = 1'b0;
        case (r_state)
            IDLE, RESP: begin
                if (w_i_win) begin
                    bus.i_gnt = 1'b1;
                    w_cmd     = '{fetch: 1'b1, we: 1'b0, err: 1'b0, op: OP_W,
                                  addr: bus.i_addr, wd: 32'd0};
                    w_next    = ACCESS;
                end else if (w_d_win) begin
                    bus.d_gnt = 1'b1;
                    w_cmd     = '{fetch: 1'b0, we: bus.d_we,
                                  err: f_illegal(bus.d_we, bus.d_op, bus.d_addr[1:0]),
                                  op: bus.d_op, addr: bus.d_addr, wd: bus.d_wdata};
                    w_next    = ACCESS;
                end else begin
                    w_next    = IDLE;
                end
            end
            ACCESS:  w_next = RESP;
            default: w_next = IDLE;
        endcase
    end

    // Memory drive: registered command during ACCESS, idle values otherwise.
    // Fetch word-aligns its address by dropping the low two bits.
    always_comb begin
        bus.mem_we      = 1'b0;
        bus.mem_addrsrc = 1'b0;
        bus.mem_memop   = OP_W;
        bus.mem_addr    = 32'd0;
        bus.mem_wd      = 32'd0;
        if (r_state == ACCESS) begin
            bus.mem_we      = !r_cmd.fetch && r_cmd.we && !r_cmd.err;
            bus.mem_addrsrc = !r_cmd.fetch;
            bus.mem_memop   = r_cmd.fetch ? OP_W : r_cmd.op;
            bus.mem_addr    = r_cmd.fetch ? {r_cmd.addr[31:2], 2'b00} : r_cmd.addr;
            bus.mem_wd      = r_cmd.wd;
        end
    end

    // Response to the owner of the command that just finished its access.
    always_comb begin
        bus.i_rvalid = (r_state == RESP) && r_cmd.fetch;
        bus.d_rvalid = (r_state == RESP) && !r_cmd.fetch;
        bus.d_err    = bus.d_rvalid && r_cmd.err;
        bus.i_rdata  = r_i_rdata;
        bus.d_rdata  = r_d_rdata;
    end

    // State, command and starvation count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= IDLE;
            r_cmd    <= '{fetch: 1'b0, we: 1'b0, err: 1'b0, op: OP_W,
                          addr: 32'd0, wd: 32'd0};
            r_starve <= 4'd0;
        end else begin
            r_state <= w_next;
            r_cmd   <= w_cmd;
            if (w_i_win)
                r_starve <= 4'd0;
            else if (w_d_win && bus.i_req && r_starve != 4'hF)
                r_starve <= r_starve + 4'd1;
        end
    end

    // Response data captured at the end of ACCESS; held until the next
    // response to the same port. Stores and errors return zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_i_rdata <= 32'd0;
            r_d_rdata <= 32'd0;
        end else if (r_state == ACCESS) begin
            if (r_cmd.fetch)
                r_i_rdata <= bus.mem_rd;
            else
                r_d_rdata <= (r_cmd.we || r_cmd.err) ? 32'd0 : bus.mem_rd;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small byte-addressable memory model
// that applies MemOp extraction and byte-lane writes.
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_checks = 0;
    int   n_pass = 0;

    mem_arbiter_if bus();

    mem_arbiter #(.STARVE_MAX(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Memory model: 64 words, combinational read, write at the rising edge.
    logic [31:0] mem [0:63];
    logic [31:0] rd_w, rd_sh;

    always_comb begin
        rd_w  = mem[bus.mem_addr[7:2]];
        rd_sh = rd_w >> (8 * bus.mem_addr[1:0]);
        case (bus.mem_memop)
            3'b001:  bus.mem_rd = {{24{rd_sh[7]}}, rd_sh[7:0]};
            3'b010:  bus.mem_rd = {{16{rd_sh[15]}}, rd_sh[15:0]};
            3'b100:  bus.mem_rd = {24'd0, rd_sh[7:0]};
            3'b101:  bus.mem_rd = {16'd0, rd_sh[15:0]};
            default: bus.mem_rd = rd_w;
        endcase
    end

    always @(posedge clk) begin
        if (bus.mem_we) begin
            case (bus.mem_memop)
                3'b001: mem[bus.mem_addr[7:2]][8*bus.mem_addr[1:0] +: 8] <= bus.mem_wd[7:0];
                3'b010: mem[bus.mem_addr[7:2]][8*bus.mem_addr[1:0] +: 16] <= bus.mem_wd[15:0];
                default: mem[bus.mem_addr[7:2]] <= bus.mem_wd;
            endcase
        end
    end

    task automatic test_reset();
        // all outputs at reset values while reset is held
        @(negedge clk); #1;
        n_checks++;
        if ({bus.i_gnt, bus.d_gnt, bus.i_rvalid, bus.d_rvalid, bus.d_err, bus.mem_we,
             bus.mem_addrsrc, bus.mem_memop} !== 9'b000000_0_011 ||
            bus.mem_addr !== 32'd0 || bus.mem_wd !== 32'd0 ||
            bus.i_rdata !== 32'd0 || bus.d_rdata !== 32'd0) begin
            $display("FAIL reset_outputs: ctl=%b addr=%h wd=%h ird=%h drd=%h, want ctl=000000_0_011 and zeros",
                     {bus.i_gnt, bus.d_gnt, bus.i_rvalid, bus.d_rvalid, bus.d_err, bus.mem_we,
                      bus.mem_addrsrc, bus.mem_memop}, bus.mem_addr, bus.mem_wd, bus.i_rdata, bus.d_rdata);
        end else n_pass++;
        reset_n = 1'b1;
        // store, then reset while it is in ACCESS
        @(negedge clk);
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_op = 3'b011;
        bus.d_addr = 32'h10; bus.d_wdata = 32'h1234_5678;
        #1;
        n_checks++;
        if (bus.d_gnt !== 1'b1) begin
            $display("FAIL rst_store_gnt: got %b want 1", bus.d_gnt);
        end else n_pass++;
        @(negedge clk);
        bus.d_req = 1'b0;
        #1;
        n_checks++;
        if (bus.mem_we !== 1'b1) begin
            $display("FAIL rst_store_we_before: got %b want 1", bus.mem_we);
        end else n_pass++;
        #1 reset_n = 1'b0;
        #1;
        n_checks++;
        if (bus.mem_we !== 1'b0) begin
            $display("FAIL rst_we_drop: got %b want 0", bus.mem_we);
        end else n_pass++;
        @(negedge clk);
        reset_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); #1;
            n_checks++;
            if ({bus.i_rvalid, bus.d_rvalid, bus.mem_we, bus.mem_addrsrc, bus.i_gnt, bus.d_gnt} !== 6'd0 ||
                bus.d_rdata !== 32'd0) begin
                $display("FAIL rst_after_release c%0d: rv=%b%b we=%b asrc=%b drd=%h, want all 0",
                         c, bus.i_rvalid, bus.d_rvalid, bus.mem_we, bus.mem_addrsrc, bus.d_rdata);
            end else n_pass++;
        end
        n_checks++;
        if (mem[4] !== 32'd0) begin
            $display("FAIL rst_no_write: mem[0x10]=%h want 00000000", mem[4]);
        end else n_pass++;
    endtask

    task automatic test_fetch();
        @(negedge clk);
        bus.i_req = 1'b1; bus.i_addr = 32'h8;
        #1;
        n_checks++;
        if ({bus.i_gnt, bus.d_gnt} !== 2'b10) begin
            $display("FAIL fetch_gnt: i/d gnt=%b want 10", {bus.i_gnt, bus.d_gnt});
        end else n_pass++;
        @(negedge clk);
        bus.i_req = 1'b0;
        #1;
        n_checks++;
        if (bus.mem_addr !== 32'h8 || bus.mem_memop !== 3'b011 || bus.mem_addrsrc !== 1'b0 ||
            bus.mem_we !== 1'b0 || bus.i_gnt !== 1'b0) begin
            $display("FAIL fetch_access: addr=%h op=%b asrc=%b we=%b gnt=%b want 8/011/0/0/0",
                     bus.mem_addr, bus.mem_memop, bus.mem_addrsrc, bus.mem_we, bus.i_gnt);
        end else n_pass++;
        @(negedge clk); #1;
        n_checks++;
        if (bus.i_rvalid !== 1'b1 || bus.d_rvalid !== 1'b0 || bus.i_rdata !== 32'h0050_0113) begin
            $display("FAIL fetch_resp: irv=%b drv=%b ird=%h want 1/0/00500113",
                     bus.i_rvalid, bus.d_rvalid, bus.i_rdata);
        end else n_pass++;
        @(negedge clk); #1;
        n_checks++;
        if (bus.i_rvalid !== 1'b0 || bus.i_rdata !== 32'h0050_0113) begin
            $display("FAIL fetch_hold: irv=%b ird=%h want 0/00500113", bus.i_rvalid, bus.i_rdata);
        end else n_pass++;
    endtask

    task automatic test_store_load();
        @(negedge clk);
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_op = 3'b011;
        bus.d_addr = 32'h4; bus.d_wdata = 32'hDEAD_BEEF;
        #1;
        n_checks++;
        if ({bus.i_gnt, bus.d_gnt} !== 2'b01) begin
            $display("FAIL store_gnt: i/d gnt=%b want 01", {bus.i_gnt, bus.d_gnt});
        end else n_pass++;
        @(negedge clk);
        bus.d_req = 1'b0;
        #1;
        n_checks++;
        if (bus.mem_we !== 1'b1 || bus.mem_addrsrc !== 1'b1 || bus.mem_memop !== 3'b011 ||
            bus.mem_addr !== 32'h4 || bus.mem_wd !== 32'hDEAD_BEEF) begin
            $display("FAIL store_access: we=%b asrc=%b op=%b addr=%h wd=%h want 1/1/011/4/deadbeef",
                     bus.mem_we, bus.mem_addrsrc, bus.mem_memop, bus.mem_addr, bus.mem_wd);
        end else n_pass++;
        @(negedge clk); #1;
        n_checks++;
        if (bus.d_rvalid !== 1'b1 || bus.d_err !== 1'b0 || bus.d_rdata !== 32'd0 || bus.mem_we !== 1'b0) begin
            $display("FAIL store_resp: rv=%b err=%b rd=%h we=%b want 1/0/0/0",
                     bus.d_rvalid, bus.d_err, bus.d_rdata, bus.mem_we);
        end else n_pass++;
        @(negedge clk);
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_op = 3'b001; bus.d_addr = 32'h7;
        #1;
        n_checks++;
        if (bus.d_gnt !== 1'b1) begin
            $display("FAIL load_gnt: got %b want 1", bus.d_gnt);
        end else n_pass++;
        @(negedge clk);
        bus.d_req = 1'b0;
        #1;
        n_checks++;
        if (bus.mem_we !== 1'b0 || bus.mem_addrsrc !== 1'b1 || bus.mem_memop !== 3'b001 ||
            bus.mem_addr !== 32'h7) begin
            $display("FAIL load_access: we=%b asrc=%b op=%b addr=%h want 0/1/001/7",
                     bus.mem_we, bus.mem_addrsrc, bus.mem_memop, bus.mem_addr);
        end else n_pass++;
        @(negedge clk); #1;
        n_checks++;
        if (bus.d_rvalid !== 1'b1 || bus.d_err !== 1'b0 || bus.d_rdata !== 32'hFFFF_FFDE) begin
            $display("FAIL load_resp: rv=%b err=%b rd=%h want 1/0/ffffffde",
                     bus.d_rvalid, bus.d_err, bus.d_rdata);
        end else n_pass++;
    endtask

    task automatic test_illegal();
        // word load at 0x6, word store at 0x2, store with op 100, legal half store at 0x2
        logic [2:0]  ops  [4] = '{3'b011, 3'b011, 3'b100, 3'b010};
        logic        wes  [4] = '{1'b0,   1'b1,   1'b1,   1'b1};
        logic [31:0] adrs [4] = '{32'h6,  32'h2,  32'h8,  32'h2};
        logic        errs [4] = '{1'b1,   1'b1,   1'b1,   1'b0};
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            bus.d_req = 1'b1; bus.d_we = wes[k]; bus.d_op = ops[k];
            bus.d_addr = adrs[k]; bus.d_wdata = 32'h0000_CAFE;
            @(negedge clk);
            bus.d_req = 1'b0;
            #1;
            n_checks++;
            if (bus.mem_we !== (wes[k] && !errs[k])) begin
                $display("FAIL illegal_we k%0d: got %b want %b", k, bus.mem_we, wes[k] && !errs[k]);
            end else n_pass++;
            @(negedge clk); #1;
            n_checks++;
            if (bus.d_rvalid !== 1'b1 || bus.d_err !== errs[k] || bus.d_rdata !== 32'd0) begin
                $display("FAIL illegal_resp k%0d: rv=%b err=%b rd=%h want 1/%b/0",
                         k, bus.d_rvalid, bus.d_err, bus.d_rdata, errs[k]);
            end else n_pass++;
        end
        n_checks++;
        if (mem[0] !== 32'hCAFE_0013) begin
            $display("FAIL illegal_mem: mem[0]=%h want cafe0013", mem[0]);
        end else n_pass++;
    endtask

    task automatic test_starvation();
        // grants on even cycles 0..18: D,D,D,D,I,D,D,D,D,I (bit set = fetch)
        logic [9:0] seq_i = 10'b10_0001_0000;
        logic [1:0] exp_g, exp_v;
        @(negedge clk);
        bus.i_req = 1'b1; bus.i_addr = 32'h0;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_op = 3'b011; bus.d_addr = 32'h4;
        for (int c = 0; c < 22; c++) begin
            if (c > 0) @(negedge clk);
            if (c == 19) begin bus.i_req = 1'b0; bus.d_req = 1'b0; end
            #1;
            exp_g = 2'b00;
            exp_v = 2'b00;
            if (c % 2 == 0 && c <= 18)
                exp_g = seq_i[c/2] ? 2'b10 : 2'b01;
            if (c % 2 == 0 && c >= 2 && c <= 20)
                exp_v = seq_i[(c-2)/2] ? 2'b10 : 2'b01;
            n_checks++;
            if ({bus.i_gnt, bus.d_gnt} !== exp_g || {bus.i_rvalid, bus.d_rvalid} !== exp_v) begin
                $display("FAIL starve c%0d: gnt(i,d)=%b rv(i,d)=%b want %b %b",
                         c, {bus.i_gnt, bus.d_gnt}, {bus.i_rvalid, bus.d_rvalid}, exp_g, exp_v);
            end else n_pass++;
        end
        n_checks++;
        if (bus.i_rdata !== 32'hCAFE_0013 || bus.d_rdata !== 32'hDEAD_BEEF) begin
            $display("FAIL starve_data: ird=%h drd=%h want cafe0013/deadbeef", bus.i_rdata, bus.d_rdata);
        end else n_pass++;
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        bus.i_req = 1'b1; bus.i_addr = 32'hB;
        @(negedge clk);
        bus.i_req = 1'b0;
        @(negedge clk);
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_op = 3'b101; bus.d_addr = 32'h6;
        #1;
        n_checks++;
        if (bus.i_rvalid !== 1'b1 || bus.d_gnt !== 1'b1 || bus.i_rdata !== 32'h0050_0113) begin
            $display("FAIL b2b_gnt_in_resp: irv=%b dgnt=%b ird=%h want 1/1/00500113",
                     bus.i_rvalid, bus.d_gnt, bus.i_rdata);
        end else n_pass++;
        @(negedge clk);
        bus.d_req = 1'b0;
        #1;
        n_checks++;
        if (bus.mem_addrsrc !== 1'b1 || bus.mem_addr !== 32'h6 || bus.mem_memop !== 3'b101 ||
            bus.d_gnt !== 1'b0) begin
            $display("FAIL b2b_access: asrc=%b addr=%h op=%b gnt=%b want 1/6/101/0",
                     bus.mem_addrsrc, bus.mem_addr, bus.mem_memop, bus.d_gnt);
        end else n_pass++;
        @(negedge clk); #1;
        n_checks++;
        if (bus.d_rvalid !== 1'b1 || bus.i_rvalid !== 1'b0 || bus.d_rdata !== 32'h0000_DEAD) begin
            $display("FAIL b2b_resp: drv=%b irv=%b drd=%h want 1/0/0000dead",
                     bus.d_rvalid, bus.i_rvalid, bus.d_rdata);
        end else n_pass++;
    endtask

    initial begin
        for (int k = 0; k < 64; k++) mem[k] = 32'd0;
        mem[0] = 32'h0000_0013;
        mem[2] = 32'h0050_0113;
        bus.i_req = 1'b0; bus.i_addr = 32'd0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_op = 3'b011;
        bus.d_addr = 32'd0; bus.d_wdata = 32'd0;
        test_reset();
        test_fetch();
        test_store_load();
        test_illegal();
        test_starvation();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter and access sequencer that shares the single unified instruction/data memory of the multicycle RISC-V core between the instruction-fetch unit and the load/store unit. It accepts one request per arbitration with a req/gnt handshake and registers the winning command. It drives the memory's `we`/`AddrSrc`/`MemOp`/`addr`/`wd` inputs for exactly one access cycle, then returns read data or a completion with a one-cycle `rvalid` pulse. Data accesses have priority; a starvation counter guarantees fetch progress.

## Interface
- `STARVE_MAX`, 4: consecutive fetch losses after which fetch wins the next arbitration (1..15).
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset. This is fixed: one clock, asynchronous active-low reset.
- `i_req` in 1: fetch request; held with `i_addr` until `i_gnt`.
- `i_addr` in 32: fetch byte address.
- `i_gnt` out 1: fetch request accepted at this edge.
- `i_rvalid` out 1: one-cycle pulse, `i_rdata` valid.
- `i_rdata` out 32: fetched word.
- `d_req` in 1: data request; held with its fields until `d_gnt`.
- `d_we` in 1: 1 = store, 0 = load.
- `d_op` in 3: MemOp encoding (001 b, 010 h, 011 w, 100 bu, 101 hu).
- `d_addr` in 32: data byte address.
- `d_wdata` in 32: store data.
- `d_gnt` out 1: data request accepted at this edge.
- `d_rvalid` out 1: one-cycle completion pulse for a load or store.
- `d_rdata` out 32: load result; 0 for stores and errors.
- `d_err` out 1: qualifies `d_rvalid`; misaligned or illegal access.
- `mem_we`, `mem_addrsrc` out 1: to memory `we`, `AddrSrc`.
- `mem_memop` out 3: to memory `MemOp`.
- `mem_addr`, `mem_wd` out 32: to memory `addr`, `wd`.
- `mem_rd` in 32: memory combinational read data.

## Operation
- States: IDLE, ACCESS, RESP. Arbitration occurs in IDLE and RESP.
- Arbitration:
  - If `d_req` is set and the starvation count is below `STARVE_MAX`, data wins.
  - Otherwise, if `i_req` is set, fetch wins.
  - Otherwise, if `d_req` is set, data wins.
  - The winner's `gnt` is asserted combinationally for that cycle. The command is registered at the edge and the state goes to ACCESS.
  - With no request, the state goes or stays IDLE.
- Starvation count, 4-bit:
  - +1, saturating, at each arbitration where `i_req` and `d_req` are both set and data wins.
  - Cleared when fetch is granted.
- Fetch command: forced `mem_memop`=011, `mem_addrsrc`=0, `mem_we`=0. `i_addr[1:0]` is ignored.
- Data command: `mem_addrsrc`=1, and `mem_memop`=`d_op`.
- Illegal data access, checked at grant:
  - Store with `d_op` outside 001..011.
  - Load with `d_op` outside 001..101.
  - Halfword with `d_addr[0]`=1.
  - Word with `d_addr[1:0]`≠00.
  - Result: the command is flagged as an error, and ACCESS drives no write (`mem_we`=0).
- ACCESS, exactly one cycle:
  - Drives the memory from the registered command. `mem_we`=1 only for a legal store.
  - For loads and fetches, `mem_rd` is captured into the response register at the end of the cycle.
  - Goes to RESP.
- RESP:
  - The owner's `rvalid` is 1 with the registered data (`d_err` per flag).
  - A new arbitration may grant in the same cycle, going to ACCESS; otherwise the state goes to IDLE.
- Outside ACCESS the memory outputs idle at: `mem_we`=0, `mem_addrsrc`=0, `mem_memop`=011, `mem_addr`=0, `mem_wd`=0.

## Timing
- Reset (async assert, sync release), all outputs:
  - State IDLE, starvation count 0.
  - `i_gnt`/`d_gnt`/`i_rvalid`/`d_rvalid`/`d_err`/`mem_we`=0.
  - `i_rdata`/`d_rdata`=0.
  - Memory outputs at the idle values.
- Reset mid-ACCESS drops `mem_we` immediately; the transaction is discarded and no `rvalid` is issued.
- Latency: `gnt` at cycle N, ACCESS at N+1, `rvalid` at N+2.
- Throughput: one access per 2 cycles under continuous requests.
- `gnt` is never asserted in ACCESS. Requests in ACCESS wait.
- `rvalid` is never asserted to both ports in the same cycle.
- `d_rdata`/`i_rdata` hold their value until the next response to that port.
- Simultaneous `i_req` and `d_req` with count below `STARVE_MAX`: data wins and the fetch waits.

## Test plan
- **Reset values:** assert `reset_n`=0 mid-store in ACCESS → `mem_we` falls in the same cycle. After release, all outputs are at reset values and there is no `rvalid`.
- **Fetch:** fetch from `i_addr`=0x8 with memory word 2 = 0x00500113 → `i_gnt` at N, `mem_addr`=0x8 and `mem_memop`=011 at N+1, `i_rvalid`=1 with `i_rdata`=0x00500113 at N+2.
- **Store then load:** store `d_op`=011 to `d_addr`=0x4 with `d_wdata`=0xDEADBEEF, then load `d_op`=001 from 0x7 → one `mem_we` pulse with `mem_addrsrc`=1, then `d_rdata`=0xFFFFFFDE.
- **Misaligned word load:** `d_op`=011 at `d_addr`=0x6 → `d_rvalid`=1, `d_err`=1, `d_rdata`=0, no `mem_we`.
- **Starvation:** hold `i_req` and `d_req` high continuously with `STARVE_MAX`=4 → grant sequence D,D,D,D,I,D,D,D,D,I. Each `rvalid` is 2 cycles after its `gnt`.
- **Back-to-back:** a new request at the RESP cycle → `gnt` in the same cycle as the previous `rvalid`, and the next ACCESS follows immediately.
